// File: rtl/spi_tuning_rx.sv
// SPI mode-0 slave that receives {voice, code} tuning frames and issues them to the DDS in slot 0.
// Optional MISO readback of the last committed frame is enabled by defining SPI_MISO_ECHO_EN.
module spi_tuning_rx #(
  parameter int unsigned VOICE_W     = 8,
  parameter int unsigned CODE_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_sclk,
  input  logic               i_mosi,
  input  logic               i_cs_n,
  input  logic [1:0]         i_pipeline_state,
  output logic               o_SPI_flag,
  output logic [CODE_W-1:0]  o_SPI_tuning_code,
  output logic [VOICE_W-1:0] o_SPI_voice_index,
  output logic               o_frame_err,
  output logic               o_overrun,
  output logic               o_miso
);

  localparam int unsigned FRAME_BITS = VOICE_W + CODE_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CntSat  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] flush_q, flush_d;
  logic                   sclk_dly_q;
  logic                   armed_q, armed_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [VOICE_W-1:0]     hold_voice_q, hold_voice_d;
  logic [CODE_W-1:0]      hold_code_q, hold_code_d;
  logic [VOICE_W-1:0]     out_voice_q, out_voice_d;
  logic [CODE_W-1:0]      out_code_q, out_code_d;
  logic                   pending_q, pending_d;
  logic                   flag_last_q;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic sclk_s, mosi_s, cs_n_s, sclk_rise, commit, issue;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign commit    = (state_q == StCommit);
  // flag_last_q guard keeps the strobe single-cycle even if slot 0 is held.
  assign issue     = pending_q & (i_pipeline_state == 2'd0) & ~flag_last_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
    flush_d     = {flush_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Arm only once the synchronisers reflect the pin and cs_n has been seen high,
  // so a chip select already low at reset release is ignored.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    armed_d     = armed_q | (flush_q[SYNC_STAGES-1] & cs_n_s);
    case (state_q)
      StIdle: begin
        if (armed_q && !cs_n_s) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (cs_n_s) begin
          if (cnt_q == CntFull) begin
            state_d = StCommit;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
          if (cnt_q != CntSat) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    hold_voice_d = hold_voice_q;
    hold_code_d  = hold_code_q;
    out_voice_d  = out_voice_q;
    out_code_d   = out_code_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    if (issue) begin
      out_voice_d = hold_voice_q;
      out_code_d  = hold_code_q;
      pending_d   = 1'b0;
    end
    // A commit coinciding with an issue refills the holding regs; pending stays set.
    if (commit) begin
      hold_voice_d = shift_q[FRAME_BITS-1 -: VOICE_W];
      hold_code_d  = shift_q[CODE_W-1:0];
      pending_d    = 1'b1;
      if (pending_q && !issue) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      cs_sync_q    <= '1;
      flush_q      <= '0;
      sclk_dly_q   <= 1'b0;
      armed_q      <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_voice_q <= '0;
      hold_code_q  <= '0;
      out_voice_q  <= '0;
      out_code_q   <= '0;
      pending_q    <= 1'b0;
      flag_last_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_sync_q    <= cs_sync_d;
      flush_q      <= flush_d;
      sclk_dly_q   <= sclk_s;
      armed_q      <= armed_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_voice_q <= hold_voice_d;
      hold_code_q  <= hold_code_d;
      out_voice_q  <= out_voice_d;
      out_code_q   <= out_code_d;
      pending_q    <= pending_d;
      flag_last_q  <= issue;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_SPI_flag        = issue;
  assign o_SPI_voice_index = issue ? hold_voice_q : out_voice_q;
  assign o_SPI_tuning_code = issue ? hold_code_q : out_code_q;
  assign o_frame_err       = frame_err_q;
  assign o_overrun         = overrun_q;

`ifdef SPI_MISO_ECHO_EN
  logic [FRAME_BITS-1:0] echo_q, echo_d;
  logic                  sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_dly_q;

  // While idle the echo register tracks the holding regs so the MSB is ready at cs_n fall.
  always_comb begin
    echo_d = echo_q;
    if (state_q == StIdle) begin
      echo_d = {hold_voice_q, hold_code_q};
    end else if (state_q == StShift && !cs_n_s && sclk_fall) begin
      echo_d = {echo_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      echo_q <= '0;
    end else begin
      echo_q <= echo_d;
    end
  end

  assign o_miso = echo_q[FRAME_BITS-1];
`else
  assign o_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tuning_rx.sv
// Self-checking bench for spi_tuning_rx: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_spi_tuning_rx;

  localparam int S    = 2;
  localparam int HALF = 5;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_sclk;
  logic        i_mosi;
  logic        i_cs_n;
  logic [1:0]  i_pipeline_state = 2'd0;
  logic        o_SPI_flag;
  logic [31:0] o_SPI_tuning_code;
  logic [7:0]  o_SPI_voice_index;
  logic        o_frame_err;
  logic        o_overrun;
  logic        o_miso;

  spi_tuning_rx #(.VOICE_W(8), .CODE_W(32), .SYNC_STAGES(S)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_sclk            (i_sclk),
    .i_mosi            (i_mosi),
    .i_cs_n            (i_cs_n),
    .i_pipeline_state  (i_pipeline_state),
    .o_SPI_flag        (o_SPI_flag),
    .o_SPI_tuning_code (o_SPI_tuning_code),
    .o_SPI_voice_index (o_SPI_voice_index),
    .o_frame_err       (o_frame_err),
    .o_overrun         (o_overrun),
    .o_miso            (o_miso)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Slot driver: cycles 0,1,2 unless slot_hold selects a fixed slot.
  int slot_hold = -1;
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge i_clk);
      #1;
      if (slot_hold >= 0) begin
        i_pipeline_state = 2'(slot_hold);
      end else begin
        i_pipeline_state = 2'(phase);
        phase = (phase == 2) ? 0 : phase + 1;
      end
    end
  end

  // Event monitor, sampled on the falling edge.
  int          flag_cnt = 0, err_cnt = 0, bad_slot = 0, consec = 0, last_flag_cyc = 0;
  logic [7:0]  last_voice = 8'h0;
  logic [31:0] last_code = 32'h0;
  logic        prev_flag = 1'b0;
  always @(negedge i_clk) begin
    if (o_SPI_flag === 1'b1) begin
      flag_cnt      <= flag_cnt + 1;
      last_voice    <= o_SPI_voice_index;
      last_code     <= o_SPI_tuning_code;
      last_flag_cyc <= cyc;
      if (i_pipeline_state != 2'd0) bad_slot <= bad_slot + 1;
      if (prev_flag) consec <= consec + 1;
    end
    if (o_frame_err === 1'b1) err_cnt <= err_cnt + 1;
    prev_flag <= o_SPI_flag;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  int cs_rise_cyc = 0;

  task automatic clock_bits(input logic [39:0] frame, input int nbits, inout logic [39:0] miso);
    for (int i = 0; i < nbits; i++) begin
      i_mosi = (i < 40) ? frame[39-i] : 1'($urandom);
      tick(HALF);
      if (i < 40) miso[39-i] = o_miso;
      i_sclk = 1'b1;
      tick(HALF);
      i_sclk = 1'b0;
    end
    tick(HALF);
  endtask

  task automatic send_frame(input logic [39:0] frame, input int nbits, output logic [39:0] miso);
    logic [39:0] m;
    m = '0;
    i_cs_n = 1'b0;
    tick(HALF);
    clock_bits(frame, nbits, m);
    i_cs_n = 1'b1;
    cs_rise_cyc = cyc;
    miso = m;
  endtask

  typedef struct {
    logic [7:0]  voice;
    logic [31:0] code;
    int          nbits;
    bit          exp_flag;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[6];
  logic [7:0]  model_voice = 8'h0;
  logic [31:0] model_code = 32'h0;
  logic [39:0] miso_word;
  int          f0, e0, rel, d;

  // Run one frame with slots cycling and compare against the frame-level model.
  task automatic frame_and_check(input string tag, input logic [7:0] v, input logic [31:0] c,
                                 input int nbits);
    bit good;
    good = (nbits == 40);
    f0 = flag_cnt;
    e0 = err_cnt;
    send_frame({v, c}, nbits, miso_word);
    tick(15);
    if (good) begin
      model_voice = v;
      model_code  = c;
    end
    check({tag, "_flag_count"}, 64'(flag_cnt - f0), 64'(good ? 1 : 0));
    check({tag, "_err_count"}, 64'(err_cnt - e0), 64'(good ? 0 : 1));
    check({tag, "_voice"}, 64'(o_SPI_voice_index), 64'(model_voice));
    check({tag, "_code"}, 64'(o_SPI_tuning_code), 64'(model_code));
    if (good) begin
      d = last_flag_cyc - cs_rise_cyc;
      check({tag, "_latency_ok"}, 64'(d >= S + 2 && d <= S + 4), 64'(1));
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_sclk  = 1'b0;
    i_mosi  = 1'b0;
    i_cs_n  = 1'b1;
    tick(3);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("reset_flag", 64'(o_SPI_flag), 64'(0));
    check("reset_voice", 64'(o_SPI_voice_index), 64'(0));
    check("reset_code", 64'(o_SPI_tuning_code), 64'(0));
    check("reset_err", 64'(o_frame_err), 64'(0));
    check("reset_overrun", 64'(o_overrun), 64'(0));
    check("reset_miso", 64'(o_miso), 64'(0));
    tick(5);

    vecs[0] = '{8'h05, 32'h0007A120, 40, 1'b1, 1'b0};
    vecs[1] = '{8'h77, 32'h13572468, 39, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 32'hFFFFFFFF, 40, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 32'h00000000, 0, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 32'h89ABCDEF, 45, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 32'h00000001, 40, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      f0 = flag_cnt;
      e0 = err_cnt;
      send_frame({vecs[k].voice, vecs[k].code}, vecs[k].nbits, miso_word);
      tick(15);
      if (vecs[k].exp_flag) begin
        model_voice = vecs[k].voice;
        model_code  = vecs[k].code;
      end
      check($sformatf("vec%0d_flag", k), 64'(flag_cnt - f0), 64'(vecs[k].exp_flag));
      check($sformatf("vec%0d_err", k), 64'(err_cnt - e0), 64'(vecs[k].exp_err));
      check($sformatf("vec%0d_voice", k), 64'(o_SPI_voice_index), 64'(model_voice));
      check($sformatf("vec%0d_code", k), 64'(o_SPI_tuning_code), 64'(model_code));
      check($sformatf("vec%0d_overrun", k), 64'(o_overrun), 64'(0));
    end

    // Slot held at 1 across the frame end: flag waits for slot 0.
    slot_hold = 1;
    f0 = flag_cnt;
    send_frame({8'h33, 32'h01020304}, 40, miso_word);
    tick(20);
    check("hold1_no_flag", 64'(flag_cnt - f0), 64'(0));
    slot_hold = -1;
    rel = cyc;
    tick(10);
    check("hold1_flag", 64'(flag_cnt - f0), 64'(1));
    check("hold1_voice", 64'(last_voice), 64'(8'h33));
    check("hold1_code", 64'(last_code), 64'(32'h01020304));
    check("hold1_release_delay_ok", 64'(last_flag_cyc - rel >= 1 && last_flag_cyc - rel <= 4),
          64'(1));
    model_voice = 8'h33;
    model_code  = 32'h01020304;

    // Two frames while slot 2 is held: second overwrites first, overrun sticks.
    slot_hold = 2;
    f0 = flag_cnt;
    send_frame({8'h01, 32'h11111111}, 40, miso_word);
    tick(10);
    send_frame({8'h02, 32'h22222222}, 40, miso_word);
    tick(10);
    check("ovr_no_flag", 64'(flag_cnt - f0), 64'(0));
    check("ovr_set", 64'(o_overrun), 64'(1));
    slot_hold = -1;
    tick(10);
    check("ovr_one_flag", 64'(flag_cnt - f0), 64'(1));
    check("ovr_voice", 64'(last_voice), 64'(8'h02));
    check("ovr_code", 64'(last_code), 64'(32'h22222222));
    model_voice = 8'h02;
    model_code  = 32'h22222222;
    frame_and_check("ovr_after", 8'h44, 32'hCAFEF00D, 40);
    check("ovr_sticky", 64'(o_overrun), 64'(1));

    // Reset after 20 bits, with cs_n still low at release.
    f0 = flag_cnt;
    e0 = err_cnt;
    miso_word = '0;
    i_cs_n = 1'b0;
    tick(HALF);
    clock_bits({8'h10, 32'h12345678}, 20, miso_word);
    i_reset = 1'b1;
    tick(2);
    i_reset = 1'b0;
    tick(1);
    check("midrst_voice", 64'(o_SPI_voice_index), 64'(0));
    check("midrst_code", 64'(o_SPI_tuning_code), 64'(0));
    check("midrst_overrun", 64'(o_overrun), 64'(0));
    clock_bits({8'h10, 32'h12345678}, 20, miso_word);
    i_cs_n = 1'b1;
    tick(15);
    check("midrst_no_flag", 64'(flag_cnt - f0), 64'(0));
    check("midrst_no_err", 64'(err_cnt - e0), 64'(0));
    model_voice = 8'h00;
    model_code  = 32'h0;
    frame_and_check("postrst", 8'h10, 32'h12345678, 40);

    // MISO readback of the previous committed frame.
    frame_and_check("echo_a", 8'hA5, 32'h0000FFFF, 40);
    frame_and_check("echo_b", 8'h5A, 32'h00000000, 40);
`ifdef SPI_MISO_ECHO_EN
    check("echo_miso", 64'(miso_word), 64'(40'hA50000FFFF));
`else
    check("echo_miso_off", 64'(miso_word), 64'(0));
`endif

    // Randomized frames against the frame-level model.
    for (int r = 0; r < 25; r++) begin
      int nb;
      nb = ($urandom_range(0, 9) < 7) ? 40 : int'($urandom_range(0, 45));
      frame_and_check($sformatf("rnd%0d", r), 8'($urandom), 32'($urandom), nb);
      tick(int'($urandom_range(0, 7)));
    end
    check("rnd_overrun", 64'(o_overrun), 64'(0));
    check("flag_only_slot0", 64'(bad_slot), 64'(0));
    check("flag_never_consecutive", 64'(consec), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
